// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Contents:
//   op_t                          2-bit shift-operation code
//   OP_SRL/OP_SRA/OP_SLL/OP_ROR   logical right, arithmetic right,
//                                 logical left, rotate right
package shifter_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_SRL = 2'b00;
  localparam op_t OP_SRA = 2'b01;
  localparam op_t OP_SLL = 2'b10;
  localparam op_t OP_ROR = 2'b11;

endpackage

// File: rtl/shifter_stage.sv
// One level of the pipelined barrel shifter.
// It shifts by SHIFT (a power of two) when the matching shift-amount bit is
// set, then registers the result together with its sideband fields.
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   advance              1 = load a new value this edge, 0 = hold (global stall)
//   up_valid/data/shamt/op/sign/tag   values from the previous level
//   dn_valid/data/shamt/op/sign/tag   registered values for the next level
//   result               combinational shift result, before the register
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int SHIFT = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               advance,
  input  logic               up_valid,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  op_t                up_op,
  input  logic               up_sign,
  input  logic [TAG_W-1:0]   up_tag,
  output logic               dn_valid,
  output logic [WIDTH-1:0]   dn_data,
  output logic [SHAMT_W-1:0] dn_shamt,
  output op_t                dn_op,
  output logic               dn_sign,
  output logic [TAG_W-1:0]   dn_tag,
  output logic [WIDTH-1:0]   result
);

  // Shift-amount bit that enables this level.
  localparam int BIT = $clog2(SHIFT);

  always_comb begin
    result = up_data;
    if (up_shamt[BIT]) begin
      case (up_op)
        OP_SRL: result = {{SHIFT{1'b0}}, up_data[WIDTH-1:SHIFT]};
        // Fill from the operand's original MSB carried down the pipe.
        OP_SRA: result = {{SHIFT{up_sign}}, up_data[WIDTH-1:SHIFT]};
        OP_SLL: result = {up_data[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
        OP_ROR: result = {up_data[SHIFT-1:0], up_data[WIDTH-1:SHIFT]};
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_shamt <= '0;
      dn_op    <= OP_SRL;
      dn_sign  <= 1'b0;
      dn_tag   <= '0;
    end else if (advance) begin
      dn_valid <= up_valid;
      dn_data  <= result;
      dn_shamt <= up_shamt;
      dn_op    <= up_op;
      dn_sign  <= up_sign;
      dn_tag   <= up_tag;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined 4-mode barrel shifter (SRL, SRA, SLL, ROR) with valid/ready
// handshakes on both sides and a sideband tag carried alongside the data.
// There are SHAMT_W = log2(WIDTH) levels, largest shift first, one register
// per level. Backpressure is a global stall: when the result is valid and
// not taken, every level holds.
// Optional feature macro: SHIFTER_STATUS_EN adds out_zero, a registered
// "result is all zeros" flag that travels with out_data.
// Ports:
//   clock, reset                   rising-edge clock, async active-high reset
//   in_valid/in_ready              input handshake
//   in_data, in_shamt, in_op, in_tag   operand, shift amount, op code, tag
//   out_valid/out_ready            output handshake
//   out_data, out_tag              shifted result and its tag
//   out_zero                       result == 0 (SHIFTER_STATUS_EN only)
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  op_t                in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
`ifdef SHIFTER_STATUS_EN
  ,
  output logic               out_zero
`endif
);

  // Index 0 is the pipe input; index gi+1 is the register of level gi.
  logic               valid_s [SHAMT_W+1];
  logic [WIDTH-1:0]   data_s  [SHAMT_W+1];
  logic [SHAMT_W-1:0] shamt_s [SHAMT_W+1];
  op_t                op_s    [SHAMT_W+1];
  logic               sign_s  [SHAMT_W+1];
  logic [TAG_W-1:0]   tag_s   [SHAMT_W+1];
  logic [SHAMT_W-1:0][WIDTH-1:0] result_s;

  logic stall;
  logic advance;

  assign stall    = valid_s[SHAMT_W] && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;

  // While stalled the first level holds, so in_valid is simply not sampled.
  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign shamt_s[0] = in_shamt;
  assign op_s[0]    = in_op;
  assign sign_s[0]  = in_data[WIDTH-1];
  assign tag_s[0]   = in_tag;

  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      shifter_stage #(
        .WIDTH(WIDTH),
        .TAG_W(TAG_W),
        .SHIFT(1 << (SHAMT_W - 1 - gi))
      ) u_stage (
        .clock    (clock),
        .reset    (reset),
        .advance  (advance),
        .up_valid (valid_s[gi]),
        .up_data  (data_s[gi]),
        .up_shamt (shamt_s[gi]),
        .up_op    (op_s[gi]),
        .up_sign  (sign_s[gi]),
        .up_tag   (tag_s[gi]),
        .dn_valid (valid_s[gi+1]),
        .dn_data  (data_s[gi+1]),
        .dn_shamt (shamt_s[gi+1]),
        .dn_op    (op_s[gi+1]),
        .dn_sign  (sign_s[gi+1]),
        .dn_tag   (tag_s[gi+1]),
        .result   (result_s[gi])
      );
    end
  endgenerate

  assign out_valid = valid_s[SHAMT_W];
  assign out_data  = data_s[SHAMT_W];
  assign out_tag   = tag_s[SHAMT_W];

`ifdef SHIFTER_STATUS_EN
  // Zero flag is taken from the last level's combinational result so it is
  // registered on the same edge as out_data and holds with it under stall.
  logic zero_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      zero_reg <= 1'b0;
    end else if (advance) begin
      zero_reg <= (result_s[SHAMT_W-1] == '0);
    end
  end

  assign out_zero = zero_reg;
`endif

  // Fields that leave the last level but have no consumer.
  logic unused_tail;
  assign unused_tail = ^{result_s, shamt_s[SHAMT_W], op_s[SHAMT_W], sign_s[SHAMT_W]};

endmodule
